// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter and the mux tree it drives.
package mux_arbiter_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_SEL_WIDTH = 2;
    localparam int DEF_MAX_HOLD  = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    // Hold counter must still have one bit when preemption is disabled.
    function automatic int hold_width(input int max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction

endpackage

// File: rtl/mux_arbiter_picker.sv
// Combinational round-robin search: first set bit of (request & ~exclude)
// starting at ptr and wrapping modulo NUM_REQ.
module rr_priority_picker
    import mux_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int SEL_WIDTH = DEF_SEL_WIDTH
) (
    input  logic [NUM_REQ-1:0]   i_request,
    input  logic [SEL_WIDTH-1:0] i_ptr,
    input  logic [NUM_REQ-1:0]   i_exclude,
    output logic                 o_found,
    output logic [SEL_WIDTH-1:0] o_winner
);

    localparam int SW1 = SEL_WIDTH + 1;

    logic [NUM_REQ-1:0] w_masked;
    logic [SEL_WIDTH:0] w_sum;

    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        w_sum    = '0;
        w_masked = i_request & ~i_exclude;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Explicit wrap so non-power-of-two NUM_REQ never indexes past the top.
            w_sum = {1'b0, i_ptr} + SW1'(k);
            if (w_sum >= SW1'(NUM_REQ)) begin
                w_sum = w_sum - SW1'(NUM_REQ);
            end
            if (!o_found && w_masked[w_sum[SEL_WIDTH-1:0]]) begin
                o_found  = 1'b1;
                o_winner = w_sum[SEL_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner sequencer for a shared mux tree; all outputs registered.
//   state     | meaning
//   ARB_IDLE  | no owner; select holds the last owner's index
//   ARB_OWNED | owner at index select holds the bus, hold counter running
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int SEL_WIDTH = DEF_SEL_WIDTH,
    parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_request,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [SEL_WIDTH-1:0] o_select,
    output logic                 o_busy
);

    localparam int                   HOLD_W    = hold_width(MAX_HOLD);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(NUM_REQ - 1);

    arb_state_t           r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [SEL_WIDTH-1:0] r_select;
    logic [SEL_WIDTH-1:0] r_ptr;
    logic [HOLD_W-1:0]    r_hold;
    logic                 r_busy;

    arb_state_t           w_state_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [SEL_WIDTH-1:0] w_select_nxt;
    logic [SEL_WIDTH-1:0] w_ptr_nxt;
    logic [HOLD_W-1:0]    w_hold_nxt;
    logic                 w_busy_nxt;

    logic [NUM_REQ-1:0]   w_owner_mask;
    logic [SEL_WIDTH-1:0] w_ptr_after;
    logic                 w_owner_req;
    logic                 w_others;
    logic                 w_release;
    logic                 w_preempt;
    logic [SEL_WIDTH-1:0] w_pick_ptr;
    logic [NUM_REQ-1:0]   w_pick_excl;
    logic                 w_found;
    logic [SEL_WIDTH-1:0] w_winner;

    assign w_owner_mask = NUM_REQ'(1) << r_select;
    assign w_ptr_after  = (r_select == LAST_IDX) ? '0 : r_select + SEL_WIDTH'(1);
    assign w_owner_req  = i_request[r_select];
    assign w_others     = |(i_request & ~w_owner_mask);
    assign w_release    = (r_state == ARB_OWNED) && !w_owner_req;
    assign w_preempt    = (r_state == ARB_OWNED) && (MAX_HOLD > 0) && (r_hold == HOLD_LAST)
                          && w_owner_req && w_others;

    // While owned, the search always restarts just past the owner and skips it.
    assign w_pick_ptr  = (r_state == ARB_OWNED) ? w_ptr_after : r_ptr;
    assign w_pick_excl = (r_state == ARB_OWNED) ? w_owner_mask : '0;

    rr_priority_picker #(
        .NUM_REQ   (NUM_REQ),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_picker (
        .i_request (i_request),
        .i_ptr     (w_pick_ptr),
        .i_exclude (w_pick_excl),
        .o_found   (w_found),
        .o_winner  (w_winner)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_select_nxt = r_select;
        w_ptr_nxt    = r_ptr;
        w_hold_nxt   = r_hold;
        w_busy_nxt   = r_busy;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = ARB_OWNED;
                    w_grant_nxt  = NUM_REQ'(1) << w_winner;
                    w_select_nxt = w_winner;
                    w_busy_nxt   = 1'b1;
                    w_hold_nxt   = '0;
                end
            end
            ARB_OWNED: begin
                if (w_release || w_preempt) begin
                    w_ptr_nxt = w_ptr_after;
                    if (w_found) begin
                        w_grant_nxt  = NUM_REQ'(1) << w_winner;
                        w_select_nxt = w_winner;
                        w_hold_nxt   = '0;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                        w_grant_nxt = '0;
                        w_busy_nxt  = 1'b0;
                    end
                end else if (r_hold != HOLD_LAST) begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_select <= '0;
            r_ptr    <= '0;
            r_hold   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_select <= w_select_nxt;
            r_ptr    <= w_ptr_nxt;
            r_hold   <= w_hold_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign o_grant  = r_grant;
    assign o_select = r_select;
    assign o_busy   = r_busy;

endmodule
